// File: rtl/pin_entry_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pin_entry_ctrl_pkg
// Shared definitions for the card-session PIN entry controller.
// Contents:
//   - counter and threshold widths
//   - BCD digit limit and default inactivity threshold
//   - FSM state encoding
//   - is_bcd() helper used to filter keypad digits
// ----------------------------------------------------------------------------
package pin_entry_ctrl_pkg;

  localparam int CNT_W    = 3;   // digit_count width
  localparam int ATT_W    = 3;   // attempts_left width (MAX_ATTEMPTS 1..7)
  localparam int THRESH_W = 32;  // timer threshold width

  localparam logic [3:0]          BCD_MAX           = 4'd9;
  localparam logic [THRESH_W-1:0] DIGIT_TIMEOUT_DEF = 32'd5000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CHECK   = 3'd2,
    ST_RETRY   = 3'd3,
    ST_GRANTED = 3'd4,
    ST_LOCKED  = 3'd5,
    ST_ABORT   = 3'd6
  } state_e;

  // True for a keypad code that is a legal decimal digit.
  function automatic logic is_bcd(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/pin_entry_ctrl_if.sv
// ----------------------------------------------------------------------------
// pin_entry_ctrl_if
// Bundles the keypad/card-reader inputs, the inactivity-timer handshake and
// the session status outputs of the PIN entry controller.
// Modports:
//   master : environment side (keypad, card reader, timer, menu logic)
//   slave  : controller side (pin_entry_ctrl)
// Signals:
//   card_in, key_valid, key_digit, key_enter, key_cancel, stored_pin, time_out
//     -> controller inputs
//   timer_start, timer_restart, timer_threshold, pin_ok, pin_fail, card_lock,
//   session_abort, attempts_left, digit_count
//     -> controller outputs
// ----------------------------------------------------------------------------
interface pin_entry_ctrl_if #(
  parameter int PIN_DIGITS = 4
);
  import pin_entry_ctrl_pkg::*;

  logic                    card_in;
  logic                    key_valid;
  logic [3:0]              key_digit;
  logic                    key_enter;
  logic                    key_cancel;
  logic [4*PIN_DIGITS-1:0] stored_pin;
  logic                    time_out;

  logic                    timer_start;
  logic                    timer_restart;
  logic [THRESH_W-1:0]     timer_threshold;
  logic                    pin_ok;
  logic                    pin_fail;
  logic                    card_lock;
  logic                    session_abort;
  logic [ATT_W-1:0]        attempts_left;
  logic [CNT_W-1:0]        digit_count;

  modport master (
    output card_in, key_valid, key_digit, key_enter, key_cancel, stored_pin, time_out,
    input  timer_start, timer_restart, timer_threshold, pin_ok, pin_fail,
           card_lock, session_abort, attempts_left, digit_count
  );

  modport slave (
    input  card_in, key_valid, key_digit, key_enter, key_cancel, stored_pin, time_out,
    output timer_start, timer_restart, timer_threshold, pin_ok, pin_fail,
           card_lock, session_abort, attempts_left, digit_count
  );

endinterface

// File: rtl/pin_entry_ctrl_digit_buffer.sv
// ----------------------------------------------------------------------------
// pin_entry_ctrl_digit_buffer
// PIN_DIGITS-deep BCD shift register with a digit counter. New digits enter
// at the LSB end, so after PIN_DIGITS shifts the first typed digit sits in the
// MSBs, matching the stored PIN layout. PIN_DIGITS must be at least 2.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   clr_i    in   clear contents and count (wins over shift_i)
//   shift_i  in   shift digit_i in and bump the count
//   digit_i  in   BCD digit to shift in
//   data_o   out  buffered digits (registered)
//   count_o  out  number of buffered digits (registered)
// The caller is responsible for never shifting into a full buffer.
// ----------------------------------------------------------------------------
module pin_entry_ctrl_digit_buffer
  import pin_entry_ctrl_pkg::*;
#(
  parameter int PIN_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    shift_i,
  input  logic [3:0]              digit_i,
  output logic [4*PIN_DIGITS-1:0] data_o,
  output logic [CNT_W-1:0]        count_o
);

  logic [4*PIN_DIGITS-1:0] data_q;
  logic [CNT_W-1:0]        count_q;

  // Digit storage and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
    end else if (clr_i) begin
      data_q  <= '0;
      count_q <= '0;
    end else if (shift_i) begin
      data_q  <= {data_q[4*PIN_DIGITS-5:0], digit_i};
      count_q <= count_q + CNT_W'(1);
    end else begin
      data_q  <= data_q;
      count_q <= count_q;
    end
  end

  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/pin_entry_ctrl.sv
// ----------------------------------------------------------------------------
// pin_entry_ctrl
// Card-session PIN entry controller. Collects keypad digits while a card is
// present, compares them with the card's stored PIN and grants the session,
// allows a retry, or locks the card once the attempts are used up. Drives the
// inactivity timer (start/restart/threshold) and aborts on its time_out.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   ctrl_io  slave modport of pin_entry_ctrl_if (keypad, card, timer, status)
// All status outputs are registered and reflect the state entered at the
// most recent clock edge; timer_threshold is the constant DIGIT_TIMEOUT.
// ----------------------------------------------------------------------------
module pin_entry_ctrl
  import pin_entry_ctrl_pkg::*;
#(
  parameter int                  PIN_DIGITS    = 4,
  parameter int                  MAX_ATTEMPTS  = 3,
  parameter logic [THRESH_W-1:0] DIGIT_TIMEOUT = DIGIT_TIMEOUT_DEF
) (
  input logic             clk,
  input logic             rst,
  pin_entry_ctrl_if.slave ctrl_io
);

  localparam logic [ATT_W-1:0] ATT_INIT  = ATT_W'(MAX_ATTEMPTS);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(PIN_DIGITS);

  state_e                  state_q, state_d;
  logic [ATT_W-1:0]        attempts_q, attempts_d;
  logic                    timer_start_q;
  logic                    timer_restart_q, restart_d;
  logic                    pin_ok_q;
  logic                    pin_fail_q, fail_d;
  logic                    card_lock_q;
  logic                    session_abort_q;

  logic                    buf_clr_s;
  logic                    buf_shift_s;
  logic [4*PIN_DIGITS-1:0] buf_data_s;
  logic [CNT_W-1:0]        buf_count_s;
  logic                    pin_match_s;

  pin_entry_ctrl_digit_buffer #(
    .PIN_DIGITS (PIN_DIGITS)
  ) u_digit_buffer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (buf_clr_s),
    .shift_i (buf_shift_s),
    .digit_i (ctrl_io.key_digit),
    .data_o  (buf_data_s),
    .count_o (buf_count_s)
  );

  // A short entry never matches, even if its digits are a prefix of the PIN.
  assign pin_match_s = (buf_count_s == CNT_FULL) && (buf_data_s == ctrl_io.stored_pin);

  // Next state, attempt counter, pulse requests and buffer control.
  always_comb begin
    state_d     = state_q;
    attempts_d  = attempts_q;
    restart_d   = 1'b0;
    fail_d      = 1'b0;
    buf_clr_s   = 1'b0;
    buf_shift_s = 1'b0;
    if (!ctrl_io.card_in) begin
      // Card removal ends the session from any state.
      state_d    = ST_IDLE;
      attempts_d = ATT_INIT;
      buf_clr_s  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_ENTRY;
          attempts_d = ATT_INIT;
          buf_clr_s  = 1'b1;
          restart_d  = 1'b1;
        end
        ST_ENTRY: begin
          if (ctrl_io.time_out || ctrl_io.key_cancel) begin
            state_d = ST_ABORT;
          end else if (ctrl_io.key_enter) begin
            // Enter wins over a simultaneous digit; the digit is dropped.
            state_d = ST_CHECK;
          end else if (ctrl_io.key_valid && is_bcd(ctrl_io.key_digit) &&
                       (buf_count_s < CNT_FULL)) begin
            buf_shift_s = 1'b1;
            restart_d   = 1'b1;
          end else begin
            state_d = ST_ENTRY;
          end
        end
        ST_CHECK: begin
          if (pin_match_s) begin
            state_d = ST_GRANTED;
          end else begin
            fail_d     = 1'b1;
            attempts_d = attempts_q - ATT_W'(1);
            if (attempts_q <= ATT_W'(1)) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_RETRY;
            end
          end
        end
        ST_RETRY: begin
          state_d   = ST_ENTRY;
          buf_clr_s = 1'b1;
          restart_d = 1'b1;
        end
        ST_GRANTED: state_d = ST_GRANTED;
        ST_LOCKED:  state_d = ST_LOCKED;
        ST_ABORT:   state_d = ST_ABORT;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state, attempt counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      attempts_q      <= ATT_INIT;
      timer_start_q   <= 1'b0;
      timer_restart_q <= 1'b0;
      pin_ok_q        <= 1'b0;
      pin_fail_q      <= 1'b0;
      card_lock_q     <= 1'b0;
      session_abort_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      attempts_q      <= attempts_d;
      timer_start_q   <= (state_d == ST_ENTRY);
      timer_restart_q <= restart_d;
      pin_ok_q        <= (state_d == ST_GRANTED);
      pin_fail_q      <= fail_d;
      card_lock_q     <= (state_d == ST_LOCKED);
      session_abort_q <= (state_d == ST_ABORT);
    end
  end

  assign ctrl_io.timer_start     = timer_start_q;
  assign ctrl_io.timer_restart   = timer_restart_q;
  assign ctrl_io.timer_threshold = DIGIT_TIMEOUT;
  assign ctrl_io.pin_ok          = pin_ok_q;
  assign ctrl_io.pin_fail        = pin_fail_q;
  assign ctrl_io.card_lock       = card_lock_q;
  assign ctrl_io.session_abort   = session_abort_q;
  assign ctrl_io.attempts_left   = attempts_q;
  assign ctrl_io.digit_count     = buf_count_s;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pin_entry_ctrl
// Directed bench for pin_entry_ctrl. A table of per-cycle records holds the
// inputs for one clock and the outputs expected right after that edge; a few
// hand-written sequences cover abort priorities and time_out handling.
// ----------------------------------------------------------------------------
module tb_pin_entry_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  pin_entry_ctrl_if #(.PIN_DIGITS(4)) bus_if ();

  pin_entry_ctrl #(
    .PIN_DIGITS    (4),
    .MAX_ATTEMPTS  (3),
    .DIGIT_TIMEOUT (32'd5000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       card;
    logic       kv;
    logic [3:0] kd;
    logic       ke;
    logic       kc;
    logic       to;
    logic       ts;
    logic       tr;
    logic       ok;
    logic       fl;
    logic       lk;
    logic       ab;
    logic [2:0] att;
    logic [2:0] cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int r, input int card, input int kv, input int kd,
                     input int ke, input int kc, input int to,
                     input int ts, input int tr, input int ok, input int fl,
                     input int lk, input int ab, input int att, input int cnt);
    vec_t v;
    v.rst = 1'(r);  v.card = 1'(card); v.kv = 1'(kv); v.kd = 4'(kd);
    v.ke = 1'(ke);  v.kc = 1'(kc);     v.to = 1'(to);
    v.ts = 1'(ts);  v.tr = 1'(tr);     v.ok = 1'(ok); v.fl = 1'(fl);
    v.lk = 1'(lk);  v.ab = 1'(ab);     v.att = 3'(att); v.cnt = 3'(cnt);
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0h exp=%0h", name, row, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic card, input logic kv, input logic [3:0] kd,
                       input logic ke, input logic kc, input logic to);
    rst               = r;
    bus_if.card_in    = card;
    bus_if.key_valid  = kv;
    bus_if.key_digit  = kd;
    bus_if.key_enter  = ke;
    bus_if.key_cancel = kc;
    bus_if.time_out   = to;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int card, input int kv, input int kd, input int ke,
                      input int kc, input int to);
    drive(1'b0, 1'(card), 1'(kv), 4'(kd), 1'(ke), 1'(kc), 1'(to));
  endtask

  task automatic check_all(input int row, input vec_t v);
    check("timer_start",   row, 32'(bus_if.timer_start),   32'(v.ts));
    check("timer_restart", row, 32'(bus_if.timer_restart), 32'(v.tr));
    check("pin_ok",        row, 32'(bus_if.pin_ok),        32'(v.ok));
    check("pin_fail",      row, 32'(bus_if.pin_fail),      32'(v.fl));
    check("card_lock",     row, 32'(bus_if.card_lock),     32'(v.lk));
    check("session_abort", row, 32'(bus_if.session_abort), 32'(v.ab));
    check("attempts_left", row, 32'(bus_if.attempts_left), 32'(v.att));
    check("digit_count",   row, 32'(bus_if.digit_count),   32'(v.cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus_if.card_in    = 1'b0;
    bus_if.key_valid  = 1'b0;
    bus_if.key_digit  = 4'd0;
    bus_if.key_enter  = 1'b0;
    bus_if.key_cancel = 1'b0;
    bus_if.time_out   = 1'b0;
    bus_if.stored_pin = 16'h1234;

    // ---- table: rst,card,kv,kd,ke,kc,to | ts,tr,ok,fl,lk,ab,att,cnt ----
    // reset values
    add(1,0,0,0,0,0,0, 0,0,0,0,0,0,3,0);
    add(0,0,0,0,0,0,0, 0,0,0,0,0,0,3,0);
    // 1: correct PIN 1234, pin_ok two cycles after enter
    add(0,1,0,0,0,0,0, 1,1,0,0,0,0,3,0);
    add(0,1,1,1,0,0,0, 1,1,0,0,0,0,3,1);
    add(0,1,1,2,0,0,0, 1,1,0,0,0,0,3,2);
    add(0,1,1,3,0,0,0, 1,1,0,0,0,0,3,3);
    add(0,1,1,4,0,0,0, 1,1,0,0,0,0,3,4);
    add(0,1,0,0,1,0,0, 0,0,0,0,0,0,3,4);
    add(0,1,0,0,0,0,0, 0,0,1,0,0,0,3,4);
    add(0,1,0,0,0,0,1, 0,0,1,0,0,0,3,4);
    add(0,0,0,0,0,0,0, 0,0,0,0,0,0,3,0);
    // 2: three wrong entries 1235 -> lock
    add(0,1,0,0,0,0,0, 1,1,0,0,0,0,3,0);
    for (int a = 0; a < 3; a++) begin
      add(0,1,1,1,0,0,0, 1,1,0,0,0,0,3-a,1);
      add(0,1,1,2,0,0,0, 1,1,0,0,0,0,3-a,2);
      add(0,1,1,3,0,0,0, 1,1,0,0,0,0,3-a,3);
      add(0,1,1,5,0,0,0, 1,1,0,0,0,0,3-a,4);
      add(0,1,0,0,1,0,0, 0,0,0,0,0,0,3-a,4);
      if (a < 2) begin
        add(0,1,0,0,0,0,0, 0,0,0,1,0,0,2-a,4);
        add(0,1,0,0,0,0,0, 1,1,0,0,0,0,2-a,0);
      end else begin
        add(0,1,0,0,0,0,0, 0,0,0,1,1,0,0,4);
        add(0,1,0,0,0,0,0, 0,0,0,0,1,0,0,4);
      end
    end
    add(0,0,0,0,0,0,0, 0,0,0,0,0,0,3,0);
    // 4: non-BCD digit and fifth digit ignored without restart
    add(0,1,0,0,0,0,0, 1,1,0,0,0,0,3,0);
    add(0,1,1,1,0,0,0, 1,1,0,0,0,0,3,1);
    add(0,1,1,2,0,0,0, 1,1,0,0,0,0,3,2);
    add(0,1,1,12,0,0,0, 1,0,0,0,0,0,3,2);
    add(0,1,1,3,0,0,0, 1,1,0,0,0,0,3,3);
    add(0,1,1,4,0,0,0, 1,1,0,0,0,0,3,4);
    add(0,1,1,5,0,0,0, 1,0,0,0,0,0,3,4);
    add(0,1,0,0,1,0,0, 0,0,0,0,0,0,3,4);
    add(0,1,0,0,0,0,0, 0,0,1,0,0,0,3,4);
    add(0,0,0,0,0,0,0, 0,0,0,0,0,0,3,0);
    // 5: short entry 123 fails, buffer cleared back in ENTRY
    add(0,1,0,0,0,0,0, 1,1,0,0,0,0,3,0);
    add(0,1,1,1,0,0,0, 1,1,0,0,0,0,3,1);
    add(0,1,1,2,0,0,0, 1,1,0,0,0,0,3,2);
    add(0,1,1,3,0,0,0, 1,1,0,0,0,0,3,3);
    add(0,1,0,0,1,0,0, 0,0,0,0,0,0,3,3);
    add(0,1,0,0,0,0,0, 0,0,0,1,0,0,2,3);
    add(0,1,0,0,0,0,0, 1,1,0,0,0,0,2,0);
    add(0,0,0,0,0,0,0, 0,0,0,0,0,0,3,0);
    // 6: enter+digit same cycle drops the digit (123 != 1234); rst mid-ENTRY
    add(0,1,0,0,0,0,0, 1,1,0,0,0,0,3,0);
    add(0,1,1,1,0,0,0, 1,1,0,0,0,0,3,1);
    add(0,1,1,2,0,0,0, 1,1,0,0,0,0,3,2);
    add(0,1,1,3,0,0,0, 1,1,0,0,0,0,3,3);
    add(0,1,1,4,1,0,0, 0,0,0,0,0,0,3,3);
    add(0,1,0,0,0,0,0, 0,0,0,1,0,0,2,3);
    add(0,1,0,0,0,0,0, 1,1,0,0,0,0,2,0);
    add(0,1,1,1,0,0,0, 1,1,0,0,0,0,2,1);
    add(1,1,1,2,0,0,0, 0,0,0,0,0,0,3,0);
    add(0,1,0,0,0,0,0, 1,1,0,0,0,0,3,0);
    add(0,0,0,0,0,0,0, 0,0,0,0,0,0,3,0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].card, vq[i].kv, vq[i].kd, vq[i].ke, vq[i].kc, vq[i].to);
      check_all(i, vq[i]);
    end

    // ---- hand-written sequences ----
    check("timer_threshold", -1, bus_if.timer_threshold, 32'd5000);

    // 3: time_out after two digits aborts; time_out ignored in ABORT; card out clears
    step(1,0,0,0,0,0);
    step(1,1,1,0,0,0);
    step(1,1,2,0,0,0);
    step(1,0,0,0,0,1);
    check("to_abort",       100, 32'(bus_if.session_abort), 32'd1);
    check("to_timer_start", 100, 32'(bus_if.timer_start),   32'd0);
    check("to_count",       100, 32'(bus_if.digit_count),   32'd2);
    step(1,0,0,0,0,1);
    check("to_abort_hold",  101, 32'(bus_if.session_abort), 32'd1);
    step(0,0,0,0,0,0);
    check("to_clr_abort",   102, 32'(bus_if.session_abort), 32'd0);
    check("to_clr_count",   102, 32'(bus_if.digit_count),   32'd0);
    check("to_clr_att",     102, 32'(bus_if.attempts_left), 32'd3);

    // cancel beats a simultaneous enter
    step(1,0,0,0,0,0);
    step(1,1,7,0,0,0);
    step(1,0,0,1,1,0);
    check("cancel_abort",   110, 32'(bus_if.session_abort), 32'd1);
    step(1,0,0,0,0,0);
    check("cancel_no_fail", 111, 32'(bus_if.pin_fail),      32'd0);
    check("cancel_hold",    111, 32'(bus_if.session_abort), 32'd1);
    step(0,0,0,0,0,0);

    // time_out beats a simultaneous enter
    step(1,0,0,0,0,0);
    step(1,0,0,1,0,1);
    check("to_vs_enter",    120, 32'(bus_if.session_abort), 32'd1);
    step(1,0,0,0,0,0);
    check("to_vs_enter_ok", 121, 32'(bus_if.pin_fail),      32'd0);
    step(0,0,0,0,0,0);

    // card removal beats time_out
    step(1,0,0,0,0,0);
    step(0,0,0,0,0,1);
    check("card_vs_to_ab",  130, 32'(bus_if.session_abort), 32'd0);
    check("card_vs_to_ts",  130, 32'(bus_if.timer_start),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
